ab_game_core: RTL
=================

# ab_game_core

Parametrised bulls-and-cows (xAyB) game engine. It generates a secret of `DIGITS` distinct decimal digits from an internal LFSR and accepts digit-by-digit guesses. Each completed guess is scored as A (right digit, right place) and B (right digit, wrong place), and the engine tracks a try budget with win/lose states. It sits between the debounce/onepulse front end and the 7-segment scan driver, and presents results as a nibble-per-digit display bus.

## Interface
- `DIGITS`, 4 — secret/guess length; legal range 4..8.
- `MAX_TRIES`, 8 — guesses allowed per game; legal range 1..15.
- `SEED`, 16'hBDBD — LFSR reset value; must be nonzero.
- `clk` input 1 — clock.
- `rst_n` input 1 — reset, synchronous, active-low.
- `start` input 1 — single-cycle pulse; begins a new game.
- `enter` input 1 — single-cycle pulse; commits `in` as the next guess digit, or acknowledges a result.
- `in` input 4 — digit to enter; values 10..15 are ignored.
- `disp` output 4*DIGITS — display nibbles; nibble DIGITS-1 is the leftmost; 4'hF means blank.
- `a_cnt` output 4 — A score of the last compared guess.
- `b_cnt` output 4 — B score of the last compared guess.
- `tries_left` output 4 — guesses remaining.
- `busy` output 1 — high in GEN and CMP.
- `win` output 1 — high in WIN.
- `lose` output 1 — high in LOSE.

## Operation
- States: IDLE, GEN, GUESS, CMP, RESULT, WIN, LOSE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle from reset.
  - Reset loads `SEED`.
  - The LFSR never halts.
- IDLE:
  - `disp` all 4'hF.
  - `start` → GEN.
- GEN:
  - Each cycle, candidate = lfsr[3:0].
  - The candidate is accepted into the next free secret slot (filled MSB first) iff it is ≤9 and not already in the secret.
  - When DIGITS slots are filled → GUESS, with `tries_left`=MAX_TRIES and the guess buffer cleared.
- GUESS:
  - `enter` with `in`≤9 shifts `in` into the guess buffer from the right; `disp` shows entered digits right-aligned, unentered positions 4'hF.
  - Repeated digits in a guess are permitted.
  - On the DIGITS-th digit → CMP.
- CMP (one cycle):
  - A = count of i with s[i]==g[i].
  - B = count of i with s[i]!=g[i] and s[i]==g[j] for some j≠i.
  - Because the secret is distinct, each secret digit contributes at most once, so A+B ≤ DIGITS.
  - `tries_left` decrements and `a_cnt`/`b_cnt` are registered.
  - Next state: A==DIGITS → WIN; else `tries_left` reaching 0 → LOSE; else → RESULT.
- RESULT:
  - `disp` low four nibbles = {A, 4'hA, B, 4'hB}; higher nibbles 4'hF.
  - `enter` → GUESS with the guess buffer cleared.
- WIN:
  - `disp` = RESULT format with A=DIGITS, B=0.
  - `start` → GEN.
- LOSE:
  - `disp` as defined under Configuration.
  - `start` → GEN.
- `start` in any state other than IDLE aborts the game and goes to GEN. The secret is regenerated and scores are cleared.
- `start` and `enter` in the same cycle: `start` wins and `enter` is dropped.
- `enter` in IDLE, GEN, CMP, WIN or LOSE is ignored.
- `in` values >9 during GUESS: no buffer change, no state change.

## Timing
- Reset values:
  - State IDLE.
  - `disp` all 4'hF.
  - `a_cnt`=`b_cnt`=0, `tries_left`=0.
  - `busy`=`win`=`lose`=0.
  - Secret and guess buffers 0.
- All outputs are registered. `disp` reflects a state one cycle after entering it.
- GEN lasts at least DIGITS cycles; the exact length is deterministic for a given `SEED` and the cycle count since reset.
- Last-digit `enter` at cycle N → CMP at N+1 → `a_cnt`/`b_cnt`/`tries_left` and the next state valid at N+2.
- `rst_n` low in any state returns every register to its reset value on the next edge, including mid-GEN and mid-guess.

## Configuration
- `AB_REVEAL_EN` defined: in LOSE, `disp` shows the secret digits.
- `AB_REVEAL_EN` undefined: in LOSE, `disp` shows the final RESULT format (last A/B).
- No other behaviour differs.

## Test plan
- Reset, then `start`:
  - `busy` is high through GEN.
  - The secret matches a bench LFSR model seeded 16'hBDBD: 4 distinct digits ≤9.
  - `tries_left`=8 on entering GUESS.
- Secret 3,7,1,5, guess 5,1,7,3 → `a_cnt`=0, `b_cnt`=4, `disp`={0,A,4,B}, `tries_left`=7.
- Secret 3,7,1,5, guess 3,3,3,3 → A=1, B=0 (repeated guess digits are not over-counted); then guess 3,7,1,5 → `win`=1, `disp`={4,A,0,B}.
- `MAX_TRIES`=2, two wrong guesses → `lose`=1 after the second CMP:
  - With `AB_REVEAL_EN`, `disp`=secret.
  - Without it, `disp`=last A/B.
- `in`=4'hC with `enter` during GUESS → no change. Simultaneous `start`+`enter` mid-guess → GEN, guess buffer cleared.
- `rst_n` low for one cycle during RESULT → all outputs at reset values the next cycle; state IDLE.

Source files
------------

// File: rtl/ab_game_core.sv
// Bulls-and-cows (xAyB) engine: LFSR-drawn secret of DIGITS distinct digits, digit-by-digit guesses, try budget.
// Optional build macro AB_REVEAL_EN: after a loss the display shows the secret instead of the final score.
module ab_game_core #(
    parameter int          DIGITS    = 4,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED      = 16'hBDBD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                enter,
    input  logic [3:0]          in,
    output logic [4*DIGITS-1:0] disp,
    output logic [3:0]          a_cnt,
    output logic [3:0]          b_cnt,
    output logic [3:0]          tries_left,
    output logic                busy,
    output logic                win,
    output logic                lose
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [2:0] {IDLE, GEN, GUESS, CMP, RESULT, WIN, LOSE} state_t;

    state_t       state;
    logic [15:0]  lfsr;
    logic [W-1:0] secret;
    logic [W-1:0] guess;
    logic [3:0]   fill;
    logic [3:0]   gcnt;
    logic [3:0]   cand;
    logic         dup;
    logic         found;
    logic [3:0]   a_calc;
    logic [3:0]   b_calc;
    logic [W-1:0] disp_nxt;

    assign cand = lfsr[3:0];

    // Secret digits shift in from the right, so the first accepted digit ends in the leftmost slot
    // and the already-filled slots are always the low `fill` nibbles.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k < int'(fill) && secret[4*k +: 4] == cand) dup = 1'b1;
        end
    end

    // B is counted per secret digit; the secret is distinct, so repeated guess digits cannot inflate it.
    always_comb begin
        a_calc = '0;
        b_calc = '0;
        found  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            found = 1'b0;
            for (int j = 0; j < DIGITS; j++) begin
                if (j != i && guess[4*j +: 4] == secret[4*i +: 4]) found = 1'b1;
            end
            if (secret[4*i +: 4] == guess[4*i +: 4]) a_calc = a_calc + 4'd1;
            else if (found)                           b_calc = b_calc + 4'd1;
        end
    end

    always_comb begin
        disp_nxt = '1;
        case (state)
            GUESS, CMP: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (k < int'(gcnt)) disp_nxt[4*k +: 4] = guess[4*k +: 4];
                end
            end
            RESULT: disp_nxt[15:0] = {a_cnt, 4'hA, b_cnt, 4'hB};
            WIN:    disp_nxt[15:0] = {4'(DIGITS), 4'hA, 4'h0, 4'hB};
            LOSE: begin
`ifdef AB_REVEAL_EN
                disp_nxt = secret;
`else
                disp_nxt[15:0] = {a_cnt, 4'hA, b_cnt, 4'hB};
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED;
            secret     <= '0;
            guess      <= '0;
            fill       <= '0;
            gcnt       <= '0;
            disp       <= '1;
            a_cnt      <= '0;
            b_cnt      <= '0;
            tries_left <= '0;
            busy       <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            disp <= disp_nxt;
            busy <= (state == GEN) || (state == CMP);
            win  <= (state == WIN);
            lose <= (state == LOSE);

            // start has priority over enter in every state, so a same-cycle enter is simply dropped.
            if (start) begin
                state  <= GEN;
                secret <= '0;
                fill   <= '0;
                guess  <= '0;
                gcnt   <= '0;
                a_cnt  <= '0;
                b_cnt  <= '0;
            end else begin
                case (state)
                    GEN: begin
                        if (cand <= 4'd9 && !dup) begin
                            secret <= {secret[W-5:0], cand};
                            fill   <= fill + 4'd1;
                            if (fill == 4'(DIGITS - 1)) begin
                                state      <= GUESS;
                                tries_left <= 4'(MAX_TRIES);
                                guess      <= '0;
                                gcnt       <= '0;
                            end
                        end
                    end
                    GUESS: begin
                        if (enter && in <= 4'd9) begin
                            guess <= {guess[W-5:0], in};
                            gcnt  <= gcnt + 4'd1;
                            if (gcnt == 4'(DIGITS - 1)) state <= CMP;
                        end
                    end
                    CMP: begin
                        a_cnt      <= a_calc;
                        b_cnt      <= b_calc;
                        tries_left <= tries_left - 4'd1;
                        if (a_calc == 4'(DIGITS))   state <= WIN;
                        else if (tries_left == 4'd1) state <= LOSE;
                        else                         state <= RESULT;
                    end
                    RESULT: begin
                        if (enter) begin
                            state <= GUESS;
                            guess <= '0;
                            gcnt  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
